// File: rtl/ami_axi_bridge_pkg.sv
// Shared AMI/AXI types and constants for the AMI-to-AXI bridge.
// Beat geometry: one 64-byte beat per AMI request.
package ami_axi_bridge_pkg;

  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam int         AMI_BEAT_BYTES = 64;
  localparam int         AMI_ADDR_ALIGN = 6;
  localparam int         AMI_DATA_W     = AMI_BEAT_BYTES * 8;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic                  valid;
    logic                  isWrite;
    logic [63:0]           addr;
    logic [AMI_DATA_W-1:0] data;
  } AMIRequest;

  typedef struct packed {
    logic                  valid;
    logic [AMI_DATA_W-1:0] data;
    logic [63:0]           size;
  } AMIResponse;

  function automatic logic [63:0] align_addr(
    input logic [63:0] a
  );
    return a & ~64'(AMI_BEAT_BYTES - 1);
  endfunction

endpackage

// File: rtl/ami_axi_bridge_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant among N requesters.
// Pointer moves to winner+1 only when advance is high and a grant exists.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] win;
  logic          found;
  int            idx;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/ami_axi_bridge.sv
// ami_axi_bridge: NUM_PORTS AMI ports onto one single-beat AXI4 master.
// Define AMI_AXI_BRIDGE_ERRCNT_EN to build the error response counter.
module ami_axi_bridge
  import ami_axi_bridge_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int ID_W            = 6,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                    clk,
  input  logic                    rst,

  output logic [ID_W-1:0]         axi_m_arid,
  output logic [63:0]             axi_m_araddr,
  output logic [7:0]              axi_m_arlen,
  output logic [2:0]              axi_m_arsize,
  output logic                    axi_m_arvalid,
  input  logic                    axi_m_arready,

  input  logic [ID_W-1:0]         axi_m_rid,
  input  logic [AMI_DATA_W-1:0]   axi_m_rdata,
  input  logic [1:0]              axi_m_rresp,
  input  logic                    axi_m_rvalid,
  output logic                    axi_m_rready,

  output logic [ID_W-1:0]         axi_m_awid,
  output logic [63:0]             axi_m_awaddr,
  output logic [7:0]              axi_m_awlen,
  output logic [2:0]              axi_m_awsize,
  output logic                    axi_m_awvalid,
  input  logic                    axi_m_awready,

  output logic [AMI_DATA_W-1:0]   axi_m_wdata,
  output logic [AMI_BEAT_BYTES-1:0] axi_m_wstrb,
  output logic                    axi_m_wlast,
  output logic                    axi_m_wvalid,
  input  logic                    axi_m_wready,

  input  logic [ID_W-1:0]         axi_m_bid,
  input  logic [1:0]              axi_m_bresp,
  input  logic                    axi_m_bvalid,
  output logic                    axi_m_bready,

  input  AMIRequest  [NUM_PORTS-1:0] mem_reqs,
  output logic       [NUM_PORTS-1:0] mem_req_grants,
  output AMIResponse [NUM_PORTS-1:0] mem_resps,
  input  logic       [NUM_PORTS-1:0] mem_resp_grants,

  output logic                    busy,
  output logic [31:0]             err_count
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]         rd_cnt [NUM_PORTS];
  logic [CW-1:0]         wr_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0]  elig;
  logic [NUM_PORTS-1:0]  gnt;
  logic [PW-1:0]         unused_arb_ptr;
  logic                  ar_free;
  logic                  aw_free;
  logic                  w_free;
  logic [ID_W-1:0]       win_id;
  logic                  win_wr;
  logic [63:0]           win_addr;
  logic [AMI_DATA_W-1:0] win_data;
  logic                  rd_go;
  logic                  wr_go;
  logic                  r_hs;
  logic                  b_hs;

  function automatic logic [CW-1:0] step(
    input logic [CW-1:0] c,
    input logic          inc,
    input logic          dec
  );
    if (inc && !dec) return c + 1'b1;
    if (dec && !inc && c != '0) return c - 1'b1;
    return c;
  endfunction

  // "Free or freeing": a register draining this cycle can reload now.
  assign ar_free = !axi_m_arvalid || axi_m_arready;
  assign aw_free = !axi_m_awvalid || axi_m_awready;
  assign w_free  = !axi_m_wvalid  || axi_m_wready;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (mem_reqs[i].valid) begin
        if (mem_reqs[i].isWrite)
          elig[i] = (wr_cnt[i] < CMAX) && aw_free && w_free;
        else
          elig[i] = (rd_cnt[i] < CMAX) && ar_free;
      end
    end
  end

  rr_arbiter #(
    .N(NUM_PORTS)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (elig),
    .advance (1'b1),
    .gnt     (gnt),
    .ptr     (unused_arb_ptr)
  );

  assign mem_req_grants = rst ? '0 : gnt;

  always_comb begin
    win_id   = '0;
    win_wr   = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        win_id   = ID_W'(i);
        win_wr   = mem_reqs[i].isWrite;
        win_addr = mem_reqs[i].addr;
        win_data = mem_reqs[i].data;
      end
    end
  end

  assign rd_go = (|mem_req_grants) && !win_wr;
  assign wr_go = (|mem_req_grants) && win_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_m_arvalid <= 1'b0;
      axi_m_arid    <= '0;
      axi_m_araddr  <= '0;
    end else if (rd_go) begin
      axi_m_arvalid <= 1'b1;
      axi_m_arid    <= win_id;
      axi_m_araddr  <= align_addr(win_addr);
    end else if (axi_m_arready) begin
      axi_m_arvalid <= 1'b0;
    end
  end

  // AW and W load together but drain on their own readies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_m_awvalid <= 1'b0;
      axi_m_awid    <= '0;
      axi_m_awaddr  <= '0;
    end else if (wr_go) begin
      axi_m_awvalid <= 1'b1;
      axi_m_awid    <= win_id;
      axi_m_awaddr  <= align_addr(win_addr);
    end else if (axi_m_awready) begin
      axi_m_awvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_m_wvalid <= 1'b0;
      axi_m_wdata  <= '0;
    end else if (wr_go) begin
      axi_m_wvalid <= 1'b1;
      axi_m_wdata  <= win_data;
    end else if (axi_m_wready) begin
      axi_m_wvalid <= 1'b0;
    end
  end

  assign axi_m_arlen  = '0;
  assign axi_m_arsize = AXI_SIZE_64B;
  assign axi_m_awlen  = '0;
  assign axi_m_awsize = AXI_SIZE_64B;
  assign axi_m_wstrb  = '1;
  assign axi_m_wlast  = 1'b1;
  assign axi_m_bready = 1'b1;

  // Unknown IDs keep rready high so stray beats are dropped.
  always_comb begin
    axi_m_rready = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      mem_resps[i].valid = 1'b0;
      mem_resps[i].data  = axi_m_rdata;
      mem_resps[i].size  = 64'(AMI_BEAT_BYTES);
      if (axi_m_rid == ID_W'(i)) begin
        mem_resps[i].valid = axi_m_rvalid && !rst;
        axi_m_rready       = mem_resp_grants[i];
      end
    end
  end

  assign r_hs = axi_m_rvalid && axi_m_rready;
  assign b_hs = axi_m_bvalid && axi_m_bready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rd_cnt[i] <= '0;
        wr_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rd_cnt[i] <= step(rd_cnt[i],
                          rd_go && win_id == ID_W'(i),
                          r_hs && axi_m_rid == ID_W'(i));
        wr_cnt[i] <= step(wr_cnt[i],
                          wr_go && win_id == ID_W'(i),
                          b_hs && axi_m_bid == ID_W'(i));
      end
    end
  end

  always_comb begin
    busy = axi_m_arvalid || axi_m_awvalid || axi_m_wvalid;
    for (int i = 0; i < NUM_PORTS; i++) begin
      busy = busy || (rd_cnt[i] != '0) || (wr_cnt[i] != '0);
    end
  end

`ifdef AMI_AXI_BRIDGE_ERRCNT_EN
  logic        r_err;
  logic        b_err;
  logic [32:0] err_sum;

  assign r_err = r_hs && (axi_m_rresp != AXI_RESP_OKAY ||
                          int'(axi_m_rid) >= NUM_PORTS);
  assign b_err = b_hs && (axi_m_bresp != AXI_RESP_OKAY ||
                          int'(axi_m_bid) >= NUM_PORTS);
  assign err_sum = {1'b0, err_count} + 33'(r_err) + 33'(b_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else begin
      err_count <= err_sum[32] ? '1 : err_sum[31:0];
    end
  end
`else
  logic unused_resp;

  assign unused_resp = ^{axi_m_rresp, axi_m_bresp};
  assign err_count   = '0;
`endif

endmodule

// File: tb/tb_ami_axi_bridge.sv
// tb_ami_axi_bridge: directed and random traffic against a queue/array
// model of the bridge; every cycle the model is compared to the DUT.
module tb_ami_axi_bridge;
  import ami_axi_bridge_pkg::*;

  localparam int NP  = 2;
  localparam int IDW = 6;
  localparam int MO  = 4;

  logic clk = 1'b0;
  logic rst;

  logic [IDW-1:0] arid, awid, rid, bid;
  logic [63:0]    araddr, awaddr;
  logic [7:0]     arlen, awlen;
  logic [2:0]     arsize, awsize;
  logic           arvalid, arready, awvalid, awready;
  logic [511:0]   rdata, wdata;
  logic [1:0]     rresp, bresp;
  logic           rvalid, rready, wvalid, wready, wlast;
  logic [63:0]    wstrb;
  logic           bvalid, bready;
  AMIRequest  [NP-1:0] mem_reqs;
  logic       [NP-1:0] mem_req_grants;
  AMIResponse [NP-1:0] mem_resps;
  logic       [NP-1:0] mem_resp_grants;
  logic           busy;
  logic [31:0]    err_count;

  ami_axi_bridge #(
    .NUM_PORTS(NP), .ID_W(IDW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .axi_m_arid(arid), .axi_m_araddr(araddr), .axi_m_arlen(arlen),
    .axi_m_arsize(arsize), .axi_m_arvalid(arvalid),
    .axi_m_arready(arready),
    .axi_m_rid(rid), .axi_m_rdata(rdata), .axi_m_rresp(rresp),
    .axi_m_rvalid(rvalid), .axi_m_rready(rready),
    .axi_m_awid(awid), .axi_m_awaddr(awaddr), .axi_m_awlen(awlen),
    .axi_m_awsize(awsize), .axi_m_awvalid(awvalid),
    .axi_m_awready(awready),
    .axi_m_wdata(wdata), .axi_m_wstrb(wstrb), .axi_m_wlast(wlast),
    .axi_m_wvalid(wvalid), .axi_m_wready(wready),
    .axi_m_bid(bid), .axi_m_bresp(bresp), .axi_m_bvalid(bvalid),
    .axi_m_bready(bready),
    .mem_reqs(mem_reqs), .mem_req_grants(mem_req_grants),
    .mem_resps(mem_resps), .mem_resp_grants(mem_resp_grants),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state
  int           m_ptr;
  int           m_rd [NP];
  int           m_wr [NP];
  bit           m_ar, m_aw, m_w;
  int           m_arid, m_awid;
  logic [63:0]  m_araddr, m_awaddr;
  logic [511:0] m_wdata;
  longint       m_err;
  int           exp_win;
  bit           exp_rready;

  // Bench-side AXI slave bookkeeping
  int  rpend[$];
  int  bq[$];
  int  wdone;
  bit  r_active;

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit port_ok(int j);
    if (!mem_reqs[j].valid) return 0;
    if (mem_reqs[j].isWrite)
      return m_wr[j] < MO && (!m_aw || awready) && (!m_w || wready);
    return m_rd[j] < MO && (!m_ar || arready);
  endfunction

  task automatic compute_exp();
    exp_win = -1;
    for (int k = 0; k < NP; k++) begin
      if (exp_win < 0 && port_ok((m_ptr + k) % NP)) exp_win = (m_ptr + k) % NP;
    end
    exp_rready = 1'b1;
    if (int'(rid) < NP) exp_rready = mem_resp_grants[rid];
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int j = 0; j < NP; j++) begin
      m_rd[j] = 0;
      m_wr[j] = 0;
    end
    m_ar = 0; m_aw = 0; m_w = 0;
    m_err = 0;
  endtask

  task automatic check_cycle();
    logic [NP-1:0] eg;
    bit eb;
    compute_exp();
    eg = '0;
    if (exp_win >= 0 && !rst) eg[exp_win] = 1'b1;
    chk("grants", mem_req_grants, eg);
    chk("err_count", err_count, m_err);
    if (rst) begin
      chk("rst_valids", {arvalid, awvalid, wvalid, busy,
                         mem_resps[0].valid, mem_resps[1].valid}, 0);
      return;
    end
    chk("arvalid", arvalid, m_ar);
    if (m_ar) chk("ar", {arid, araddr}, {6'(m_arid), m_araddr});
    chk("awvalid", awvalid, m_aw);
    if (m_aw) chk("aw", {awid, awaddr}, {6'(m_awid), m_awaddr});
    chk("wvalid", wvalid, m_w);
    if (m_w) chk("wdata", wdata, m_wdata);
    chk("fixed", {arlen, arsize, awlen, awsize, wstrb, wlast, bready},
        {8'd0, 3'd6, 8'd0, 3'd6, {64{1'b1}}, 1'b1, 1'b1});
    chk("rready", rready, exp_rready);
    for (int i = 0; i < NP; i++) begin
      eb = rvalid && int'(rid) == i;
      chk("resp_valid", mem_resps[i].valid, eb);
      if (eb) chk("resp_data", {mem_resps[i].size, mem_resps[i].data},
                  {64'd64, rdata});
    end
    eb = m_ar || m_aw || m_w;
    for (int j = 0; j < NP; j++) eb = eb || m_rd[j] != 0 || m_wr[j] != 0;
    chk("busy", busy, eb);
  endtask

  task automatic model_update();
    bit ar_hs, aw_hs, w_hs, r_hs;
    int inc, dec, n;
    if (rst) return;
    ar_hs = m_ar && arready;
    aw_hs = m_aw && awready;
    w_hs  = m_w && wready;
    r_hs  = rvalid && exp_rready;
    if (ar_hs) rpend.push_back(m_arid);
    if (aw_hs) bq.push_back(m_awid);
    if (w_hs) wdone++;
    if (r_hs) r_active = 0;
    for (int j = 0; j < NP; j++) begin
      inc = (exp_win == j && !mem_reqs[j].isWrite) ? 1 : 0;
      dec = (r_hs && int'(rid) == j) ? 1 : 0;
      m_rd[j] = m_rd[j] + inc - dec;
      if (m_rd[j] < 0) m_rd[j] = 0;
      inc = (exp_win == j && mem_reqs[j].isWrite) ? 1 : 0;
      dec = (bvalid && int'(bid) == j) ? 1 : 0;
      m_wr[j] = m_wr[j] + inc - dec;
      if (m_wr[j] < 0) m_wr[j] = 0;
    end
    if (exp_win >= 0 && !mem_reqs[exp_win].isWrite) begin
      m_ar = 1; m_arid = exp_win;
      m_araddr = mem_reqs[exp_win].addr - (mem_reqs[exp_win].addr % 64);
    end else if (ar_hs) m_ar = 0;
    if (exp_win >= 0 && mem_reqs[exp_win].isWrite) begin
      m_aw = 1; m_w = 1; m_awid = exp_win;
      m_awaddr = mem_reqs[exp_win].addr - (mem_reqs[exp_win].addr % 64);
      m_wdata = mem_reqs[exp_win].data;
    end else begin
      if (aw_hs) m_aw = 0;
      if (w_hs) m_w = 0;
    end
    if (exp_win >= 0) m_ptr = (exp_win + 1) % NP;
`ifdef AMI_AXI_BRIDGE_ERRCNT_EN
    n = 0;
    if (r_hs && (rresp != 0 || int'(rid) >= NP)) n++;
    if (bvalid && (bresp != 0 || int'(bid) >= NP)) n++;
    m_err = m_err + n;
    if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
`else
    n = 0;
`endif
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < NP; i++) begin
      mem_reqs[i] = '0;
    end
    mem_resp_grants = '0;
    arready = 1; awready = 1; wready = 1;
    rvalid = 0; rid = '0; rdata = '0; rresp = 0;
    bvalid = 0; bid = '0; bresp = 0;
    r_active = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    idle();
    #2;
    chk("rst_state", {arvalid, awvalid, wvalid, busy, mem_req_grants}, 0);
    chk("rst_err", err_count, 0);
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic set_req(int p, bit wr, logic [63:0] a);
    mem_reqs[p].valid   = 1;
    mem_reqs[p].isWrite = wr;
    mem_reqs[p].addr    = a;
    mem_reqs[p].data    = {16{$urandom}};
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NP; i++) begin
      mem_reqs[i].valid   = $urandom_range(0, 2) != 0;
      mem_reqs[i].isWrite = $urandom_range(0, 1);
      mem_reqs[i].addr    = {$urandom, $urandom};
      mem_reqs[i].data    = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
    end
    mem_resp_grants = NP'($urandom);
    arready = $urandom_range(0, 3) != 0;
    awready = $urandom_range(0, 3) != 0;
    wready  = $urandom_range(0, 3) != 0;
    if (!r_active) begin
      if (rpend.size() > 0 && $urandom_range(0, 2) == 0) begin
        rid = 6'(rpend.pop_front());
        r_active = 1;
      end else if ($urandom_range(0, 40) == 0) begin
        rid = 6'd9;
        r_active = 1;
      end
      if (r_active) begin
        rdata = {16{$urandom}};
        rresp = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
      end
    end
    rvalid = r_active;
    bvalid = 0;
    if (bq.size() > 0 && wdone > 0 && $urandom_range(0, 2) == 0) begin
      bid = 6'(bq.pop_front());
      wdone--;
      bvalid = 1;
      bresp = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'b00;
    end else if ($urandom_range(0, 60) == 0) begin
      bid = 6'd12;
      bvalid = 1;
      bresp = 2'b00;
    end
  endtask

  initial begin
    wdone = 0;
    do_reset();

    // Read round-robin
    set_req(0, 0, 64'h1000);
    set_req(1, 0, 64'h2040);
    for (int k = 0; k < 6; k++) begin
      #2;
      chk("rr_gnt", mem_req_grants, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) begin
        chk("rr_araddr", araddr, (k % 2) ? 64'h1000 : 64'h2040);
        chk("rr_arid", arid, (k % 2) ? 6'd0 : 6'd1);
      end
      cycle();
    end
    idle();
    cycle();

    // Response routing with a stalled consumer
    rvalid = 1; rid = 6'd1; rdata = {16{32'hA5A5_0001}};
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("route_v1", mem_resps[1].valid, 1'b1);
      chk("route_v0", mem_resps[0].valid, 1'b0);
      chk("route_rready", rready, 1'b0);
      cycle();
    end
    mem_resp_grants = 2'b10;
    #2;
    chk("route_rready_on", rready, 1'b1);
    cycle();
    idle();
    cycle();

    // Read credits
    do_reset();
    set_req(0, 0, 64'h1234_5677);
    for (int k = 0; k < 7; k++) begin
      #2;
      chk("cred_gnt", mem_req_grants, (k < 4) ? 2'b01 : 2'b00);
      if (k == 1) chk("cred_align", araddr, 64'h1234_5640);
      cycle();
    end
    rvalid = 1; rid = 6'd0; mem_resp_grants = 2'b01;
    #2;
    chk("cred_same_cycle", mem_req_grants, 2'b00);
    cycle();
    rvalid = 0;
    #2;
    chk("cred_next_cycle", mem_req_grants, 2'b01);
    cycle();
    idle();
    cycle();

    // Write decoupling
    do_reset();
    wready = 0;
    set_req(0, 1, 64'h4000);
    for (int k = 0; k < 7; k++) begin
      if (k == 6) wready = 1;
      #2;
      chk("wd_gnt", mem_req_grants, (k == 0 || k == 6) ? 2'b01 : 2'b00);
      if (k >= 1) begin
        chk("wd_wvalid", wvalid, 1'b1);
        chk("wd_awvalid", awvalid, k == 1);
        chk("wd_wstrb", wstrb, {64{1'b1}});
      end
      cycle();
    end
    idle();
    cycle();
    cycle();

    // Reset mid-flight
    do_reset();
    set_req(0, 0, 64'h8000);
    for (int k = 0; k < 3; k++) cycle();
    idle();
    cycle();
    cycle();
    rst = 1;
    model_reset();
    cycle();
    rst = 0;
    rvalid = 1; rid = 6'd0; mem_resp_grants = 2'b01;
    for (int k = 0; k < 3; k++) cycle();
    idle();
    #2;
    chk("mf_busy", busy, 1'b0);
    chk("mf_valids", {arvalid, awvalid, wvalid, mem_req_grants,
                      mem_resps[0].valid, mem_resps[1].valid}, 0);
    cycle();

    // Error responses in the same cycle
    do_reset();
    rvalid = 1; rid = 6'd0; rresp = 2'b11; mem_resp_grants = 2'b01;
    bvalid = 1; bid = 6'd0; bresp = 2'b10;
    cycle();
    idle();
    #2;
`ifdef AMI_AXI_BRIDGE_ERRCNT_EN
    chk("err_two", err_count, 32'd2);
`else
    chk("err_two", err_count, 32'd0);
`endif
    cycle();

    // Random traffic
    rpend.delete();
    bq.delete();
    wdone = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
